// File: rtl/ctrl_cmd_pkg.sv
// Shared types and opcodes for the UART command sequencer.
package ctrl_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ROW,
    GET_PIXELS,
    GET_BRIGHT,
    CLEAR
  } cmd_state_e;

  localparam logic [7:0] CMD_ROW_LOAD = 8'h4C;
  localparam logic [7:0] CMD_BRIGHT   = 8'h62;
  localparam logic [7:0] CMD_CLEAR    = 8'h72;
  localparam logic [7:0] CMD_COMMIT   = 8'h52;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte watchdog: counts idle cycles while enabled, expires on the
// last allowed tick unless a byte (clear) arrives in that same cycle.
module cmd_timeout_counter #(
  parameter logic [15:0] TIMEOUT_TICKS = 16'd2000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  logic [15:0] count_q;

  assign expire = enable && !clear && (count_q == TIMEOUT_TICKS - 16'd1);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear || !enable || expire) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/control_cmd_sequencer.sv
// Parses the UART byte stream into row-load / brightness / clear / commit
// commands and drives the framebuffer byte write port.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// GET_ROW    | waiting for the row number after 'L'
// GET_PIXELS | consuming one row of payload bytes
// GET_BRIGHT | waiting for the brightness value after 'b'
// CLEAR      | writing zero to every framebuffer byte
module control_cmd_sequencer
  import ctrl_cmd_pkg::*;
#(
  parameter int          PIXEL_WIDTH      = 64,
  parameter int          PIXEL_HEIGHT     = 32,
  parameter int          BYTES_PER_PIXEL  = 2,
  parameter logic [15:0] TIMEOUT_TICKS    = 16'd2000,
  parameter logic [7:0]  BRIGHTNESS_RESET = 8'hFF,
  localparam int         ADDR_W           = $clog2(PIXEL_HEIGHT*PIXEL_WIDTH*BYTES_PER_PIXEL)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic [7:0]        brightness,
  output logic              frame_commit,
  output logic              busy,
  output logic              cmd_error
);

  localparam int ROW_BYTES   = PIXEL_WIDTH*BYTES_PER_PIXEL;
  localparam int FRAME_BYTES = PIXEL_HEIGHT*ROW_BYTES;
  localparam int IDX_W       = $clog2(ROW_BYTES);
  localparam int ROW_W       = $clog2(PIXEL_HEIGHT);

  cmd_state_e         state_q, state_d;
  logic [ROW_W-1:0]   row_q;
  logic               suppress_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ADDR_W-1:0]  clr_addr_q;
  logic [ADDR_W-1:0]  pix_addr;

  logic pix_wr, clr_wr, err_d, commit_d;
  logic row_bad, idx_last, clr_last;
  logic tmo_en, tmo_expire;

  assign row_bad  = 32'(rx_data) >= PIXEL_HEIGHT;
  assign idx_last = idx_q == IDX_W'(ROW_BYTES - 1);
  assign clr_last = clr_addr_q == ADDR_W'(FRAME_BYTES - 1);
  assign pix_addr = ADDR_W'(row_q) * ADDR_W'(ROW_BYTES) + ADDR_W'(idx_q);
  assign tmo_en   = (state_q == GET_ROW) || (state_q == GET_PIXELS) || (state_q == GET_BRIGHT);
  assign busy     = state_q != IDLE;

  cmd_timeout_counter #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk_in(clk_in),
    .reset (reset),
    .enable(tmo_en),
    .clear (rx_valid),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pix_wr   = 1'b0;
    clr_wr   = 1'b0;
    err_d    = 1'b0;
    commit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_ROW_LOAD: state_d  = GET_ROW;
            CMD_BRIGHT:   state_d  = GET_BRIGHT;
            CMD_CLEAR:    state_d  = CLEAR;
            CMD_COMMIT:   commit_d = 1'b1;
            default:      ;
          endcase
        end
      end
      GET_ROW: begin
        if (rx_valid) begin
          state_d = GET_PIXELS;
          err_d   = row_bad;
        end else if (tmo_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_PIXELS: begin
        if (rx_valid) begin
          pix_wr = !suppress_q;
          if (idx_last) state_d = IDLE;
        end else if (tmo_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_BRIGHT: begin
        if (rx_valid) begin
          state_d = IDLE;
        end else if (tmo_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        err_d  = rx_valid;
        if (clr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
      brightness   <= BRIGHTNESS_RESET;
      frame_commit <= 1'b0;
      cmd_error    <= 1'b0;
      row_q        <= '0;
      suppress_q   <= 1'b0;
      idx_q        <= '0;
      clr_addr_q   <= '0;
    end else begin
      ram_wr_en    <= pix_wr || clr_wr;
      frame_commit <= commit_d;
      cmd_error    <= err_d;
      if (pix_wr) begin
        ram_wr_addr <= pix_addr;
        ram_wr_data <= rx_data;
      end else if (clr_wr) begin
        ram_wr_addr <= clr_addr_q;
        ram_wr_data <= '0;
      end
      if (state_q == GET_ROW && rx_valid) begin
        row_q      <= rx_data[ROW_W-1:0];
        suppress_q <= row_bad;
        idx_q      <= '0;
      end
      if (state_q == GET_PIXELS && rx_valid) idx_q <= idx_last ? '0 : idx_q + 1'b1;
      if (state_q == GET_BRIGHT && rx_valid) brightness <= rx_data;
      // Clear address parks at zero outside CLEAR so every clear starts at 0.
      if (state_q == CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
      else                  clr_addr_q <= '0;
    end
  end

endmodule

// File: tb/tb_control_cmd_sequencer.sv
// Self-checking bench: per-cycle comparison against a timestamp-based
// command-stream model, directed scenarios plus a randomized command mix.
module tb_control_cmd_sequencer;

  localparam int ROW_BYTES   = 128;
  localparam int HEIGHT      = 32;
  localparam int FRAME_BYTES = 4096;
  localparam int TMO         = 2000;

  localparam int M_IDLE = 0, M_ROW = 1, M_PIX = 2, M_BRIGHT = 3, M_CLEAR = 4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ram_wr_en;
  logic [11:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  brightness;
  logic        frame_commit;
  logic        busy;
  logic        cmd_error;

  control_cmd_sequencer dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .brightness  (brightness),
    .frame_commit(frame_commit),
    .busy        (busy),
    .cmd_error   (cmd_error)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0;
  int t = 0;
  int n_wr, n_err, n_com;

  // model state: command context plus timestamps of the last accepted byte / clear start
  int         m_mode = M_IDLE;
  int         last_t, clr_t, m_row, m_got;
  bit         m_bad;
  logic [7:0] m_bright = 8'hFF;

  bit         e_wr, e_err, e_com, e_busy;
  int         e_addr;
  logic [7:0] e_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic model(input bit v, input logic [7:0] d);
    e_wr = 0; e_err = 0; e_com = 0; e_addr = 0; e_data = 8'h00;
    if (m_mode == M_CLEAR) begin
      e_wr   = 1;
      e_addr = t - clr_t - 1;
      e_err  = v;
      if (e_addr == FRAME_BYTES - 1) m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (v) begin
        last_t = t;
        if      (d == 8'h4C) m_mode = M_ROW;
        else if (d == 8'h62) m_mode = M_BRIGHT;
        else if (d == 8'h72) begin m_mode = M_CLEAR; clr_t = t; end
        else if (d == 8'h52) e_com = 1;
      end
    end else if (v) begin
      last_t = t;
      if (m_mode == M_ROW) begin
        m_row = int'(d);
        m_bad = m_row >= HEIGHT;
        e_err = m_bad;
        m_got = 0;
        m_mode = M_PIX;
      end else if (m_mode == M_PIX) begin
        if (!m_bad) begin
          e_wr   = 1;
          e_addr = m_row * ROW_BYTES + m_got;
          e_data = d;
        end
        m_got++;
        if (m_got == ROW_BYTES) m_mode = M_IDLE;
      end else begin
        m_bright = d;
        m_mode = M_IDLE;
      end
    end else if (t - last_t >= TMO) begin
      e_err  = 1;
      m_mode = M_IDLE;
    end
    e_busy = m_mode != M_IDLE;
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    model(v, d);
    @(posedge clk_in); #1;
    chk("ctl{wr,err,commit,busy}", {28'd0, ram_wr_en, cmd_error, frame_commit, busy},
        {28'd0, e_wr, e_err, e_com, e_busy});
    chk("brightness", {24'd0, brightness}, {24'd0, m_bright});
    if (e_wr) chk("wr{addr,data}", {12'd0, ram_wr_addr, ram_wr_data}, {12'd0, 12'(e_addr), e_data});
    if (ram_wr_en)    n_wr++;
    if (cmd_error)    n_err++;
    if (frame_commit) n_com++;
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    idle(gap);
    step(1'b1, d);
  endtask

  task automatic clr_win();
    n_wr = 0; n_err = 0; n_com = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outs"}, {8'd0, ram_wr_en, cmd_error, frame_commit, busy, ram_wr_addr, ram_wr_data}, 32'd0);
    chk({tag, "_bright"}, {24'd0, brightness}, 32'h0000_00FF);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_mode = M_IDLE;
    m_bright = 8'hFF;
    @(posedge clk_in); @(posedge clk_in); #1;
    t += 2;
    reset = 1'b1;
  endtask

  task automatic row_load(input logic [7:0] row, input int nbytes, input int maxgap);
    send(8'h4C, $urandom_range(0, maxgap));
    send(row, $urandom_range(0, maxgap));
    for (int i = 0; i < nbytes; i++) send(8'($urandom), $urandom_range(0, maxgap));
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    t = 3;
    chk_reset_outputs("por");
    reset = 1'b1;

    // row load: 'L',4, payload 0x00..0x7F
    clr_win();
    send(8'h4C, 1); send(8'h04, 0);
    for (int i = 0; i < ROW_BYTES; i++) send(8'(i), $urandom_range(0, 2));
    idle(3);
    chk("rowload_writes", n_wr, 128);
    chk("rowload_errors", n_err, 0);

    // brightness then commit
    clr_win();
    send(8'h62, 2); send(8'h40, 1); send(8'h52, 3);
    idle(3);
    chk("bright_commit_pulses", n_com, 1);
    chk("bright_commit_writes", n_wr, 0);

    // bad row consumes a row silently, next load is normal
    clr_win();
    send(8'h4C, 1); send(8'h20, 0);
    for (int i = 0; i < ROW_BYTES; i++) send(8'($urandom), $urandom_range(0, 1));
    idle(2);
    chk("badrow_errors", n_err, 1);
    chk("badrow_writes", n_wr, 0);
    send(8'h4C, 0); send(8'h00, 0);
    for (int i = 0; i < ROW_BYTES; i++) send(8'(i ^ 8'hA5), 0);
    idle(2);
    chk("row0_writes", n_wr, 128);

    // truncated row recovers through the timeout
    clr_win();
    send(8'h4C, 0); send(8'h01, 0);
    for (int i = 0; i < 10; i++) send(8'($urandom), 0);
    idle(TMO + 2);
    chk("timeout_writes", n_wr, 10);
    chk("timeout_errors", n_err, 1);
    send(8'h62, 0); send(8'h10, 0);
    idle(2);

    // byte exactly at the expiry tick wins; one tick later it does not
    clr_win();
    send(8'h4C, 0); send(8'h02, 0);
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    idle(TMO - 1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    idle(TMO);
    send(8'h62, 0); send(8'h22, 0);
    idle(2);
    chk("edge_tmo_writes", n_wr, 10);
    chk("edge_tmo_errors", n_err, 1);

    // clear with a dropped byte in the middle
    clr_win();
    send(8'h72, 1);
    send(8'h5A, 699);
    idle(3405);
    chk("clear_writes", n_wr, FRAME_BYTES);
    chk("clear_errors", n_err, 1);

    // reset in the middle of a row
    send(8'h62, 0); send(8'h33, 0);
    send(8'h4C, 0); send(8'h03, 0);
    for (int i = 0; i < 50; i++) send(8'($urandom), 0);
    do_reset();
    clr_win();
    row_load(8'h05, ROW_BYTES, 1);
    idle(2);
    chk("post_reset_writes", n_wr, 128);

    // randomized command mix
    for (int k = 0; k < 25; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        int n;
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 127) : ROW_BYTES;
        row_load(8'($urandom_range(0, 39)), n, 2);
        if (n < ROW_BYTES) idle(TMO + $urandom_range(1, 4));
      end else if (kind == 4) begin
        send(8'h62, $urandom_range(0, 3)); send(8'($urandom), $urandom_range(0, 3));
      end else if (kind == 5) begin
        send(8'h52, $urandom_range(0, 3));
      end else if (kind == 6) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'h4C || g == 8'h62 || g == 8'h72 || g == 8'h52) g = g ^ 8'h01;
        send(g, $urandom_range(0, 3));
      end else begin
        idle($urandom_range(1, 20));
      end
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
